// File: rtl/div_pipe_7_pkg.sv
// Shared defaults for the pipelined restoring divider.
package div_pipe_7_pkg;

  // Default dividend/quotient width; also the pipeline depth.
  localparam int unsigned DEF_WIDTH_N = 16;
  // Default divisor/remainder width.
  localparam int unsigned DEF_WIDTH_D = 8;

endpackage

// File: rtl/div_cell_7.sv
// One bit-stage of the restoring divider: shifts in the next dividend bit,
// trial-subtracts the divisor and appends one quotient bit.
module div_cell_7
  import div_pipe_7_pkg::*;
#(
  parameter int unsigned WIDTH_N = DEF_WIDTH_N,
  parameter int unsigned WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH_D-1:0] rem_in,
  input  logic [WIDTH_N-1:0] dvd_in,
  input  logic [WIDTH_N-1:0] quo_in,
  input  logic [WIDTH_D-1:0] dsr_in,
  input  logic               zero_in,
  output logic               rdy,
  output logic [WIDTH_D-1:0] rem_out,
  output logic [WIDTH_N-1:0] dvd_out,
  output logic [WIDTH_N-1:0] quo_out,
  output logic [WIDTH_D-1:0] dsr_out,
  output logic               zero_out
);

  logic [WIDTH_D:0]   t;
  logic [WIDTH_D-1:0] rem_nxt;
  logic               q_bit;
  // The quotient MSB shifts out of the word; it is always zero by construction.
  logic               unused_quo_msb;

  assign unused_quo_msb = quo_in[WIDTH_N-1];

  // Trial subtraction; a zero divisor forces a 1 quotient bit and zero remainder
  // so the op leaves the pipe as all-ones / 0 without extra output muxing.
  always_comb begin
    t       = {rem_in, dvd_in[WIDTH_N-1]};
    rem_nxt = '0;
    q_bit   = 1'b0;
    if (zero_in) begin
      rem_nxt = '0;
      q_bit   = 1'b1;
    end else if (t >= {1'b0, dsr_in}) begin
      rem_nxt = WIDTH_D'(t - {1'b0, dsr_in});
      q_bit   = 1'b1;
    end else begin
      rem_nxt = t[WIDTH_D-1:0];
      q_bit   = 1'b0;
    end
  end

  // Stage registers: valid advances every cycle, data loads only with valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy      <= 1'b0;
      rem_out  <= '0;
      dvd_out  <= '0;
      quo_out  <= '0;
      dsr_out  <= '0;
      zero_out <= 1'b0;
    end else begin
      rdy <= en;
      if (en) begin
        rem_out  <= rem_nxt;
        dvd_out  <= {dvd_in[WIDTH_N-2:0], 1'b0};
        quo_out  <= {quo_in[WIDTH_N-2:0], q_bit};
        dsr_out  <= dsr_in;
        zero_out <= zero_in;
      end
    end
  end

endmodule

// File: rtl/div_pipe_7.sv
// Fully pipelined unsigned restoring divider: WIDTH_N bit-stages, one op per
// clock, results in issue order WIDTH_N cycles after issue.
module div_pipe_7
  import div_pipe_7_pkg::*;
#(
  parameter int unsigned WIDTH_N = DEF_WIDTH_N,
  parameter int unsigned WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_zero,
  output logic               result_rdy
);

  // Index k is the input of stage k; index WIDTH_N is the last stage output.
  logic [WIDTH_N:0]              vld_c;
  logic [WIDTH_N:0][WIDTH_D-1:0] rem_c;
  logic [WIDTH_N:0][WIDTH_N-1:0] dvd_c;
  logic [WIDTH_N:0][WIDTH_N-1:0] quo_c;
  logic [WIDTH_N:0][WIDTH_D-1:0] dsr_c;
  logic [WIDTH_N:0]              zero_c;
  // The residual dividend and divisor copy are not needed past the last stage.
  logic                          unused_tail;

  assign vld_c[0]  = en;
  assign rem_c[0]  = '0;
  assign dvd_c[0]  = dividend;
  assign quo_c[0]  = '0;
  assign dsr_c[0]  = divisor;
  assign zero_c[0] = (divisor == {WIDTH_D{1'b0}});

  for (genvar k = 0; k < WIDTH_N; k++) begin : g_stage
    div_cell_7 #(
      .WIDTH_N (WIDTH_N),
      .WIDTH_D (WIDTH_D)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (vld_c[k]),
      .rem_in   (rem_c[k]),
      .dvd_in   (dvd_c[k]),
      .quo_in   (quo_c[k]),
      .dsr_in   (dsr_c[k]),
      .zero_in  (zero_c[k]),
      .rdy      (vld_c[k+1]),
      .rem_out  (rem_c[k+1]),
      .dvd_out  (dvd_c[k+1]),
      .quo_out  (quo_c[k+1]),
      .dsr_out  (dsr_c[k+1]),
      .zero_out (zero_c[k+1])
    );
  end

  assign unused_tail = ^{dvd_c[WIDTH_N], dsr_c[WIDTH_N]};

  // Outputs come straight from the last stage registers, which hold between ops.
  assign quotient   = quo_c[WIDTH_N];
  assign remainder  = rem_c[WIDTH_N];
  assign div_zero   = zero_c[WIDTH_N];
  assign result_rdy = vld_c[WIDTH_N];

endmodule

// File: tb/tb_div_pipe_7.sv
// Directed self-checking bench for div_pipe_7 (16/8 configuration).
module tb_div_pipe_7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        result_rdy;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q_fifo [$];
  logic [7:0]  exp_r_fifo [$];
  logic [15:0] last_q;
  logic [7:0]  last_r;
  logic        last_z;

  div_pipe_7 #(.WIDTH_N(16), .WIDTH_D(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero),
    .result_rdy (result_rdy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one isolated op and check exact latency, result and output hold.
  task automatic run_single(input string tag, input logic [15:0] a, input logic [7:0] b,
                            input logic [15:0] eq, input logic [7:0] er, input logic ez);
    int early;
    dividend = a;
    divisor  = b;
    en       = 1'b1;
    step();
    en    = 1'b0;
    early = 0;
    repeat (14) begin
      step();
      if (result_rdy !== 1'b0) early++;
    end
    check({tag, "_early_rdy"}, early, 0);
    step();
    check({tag, "_rdy"}, result_rdy, 1'b1);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_z"}, div_zero, ez);
    step();
    check({tag, "_rdy_off"}, result_rdy, 1'b0);
    check({tag, "_q_hold"}, quotient, eq);
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  logic       pat [6];
  logic       exp_rdy;
  int unsigned a_u;
  int unsigned b_u;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    dividend = 16'd999;
    divisor  = 8'd3;
    last_q   = 16'd0;
    last_r   = 8'd0;
    last_z   = 1'b0;
    repeat (3) step();
    check("reset_rdy", result_rdy, 1'b0);
    check("reset_q", quotient, 16'd0);
    check("reset_r", remainder, 8'd0);
    check("reset_z", div_zero, 1'b0);
    rst_n = 1'b1;
    en    = 1'b0;

    run_single("d1000_7", 16'h03E8, 8'd7, 16'd142, 8'd6, 1'b0);
    run_single("d65535_255", 16'hFFFF, 8'd255, 16'd257, 8'd0, 1'b0);
    run_single("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
    run_single("d0_3", 16'd0, 8'd3, 16'd0, 8'd0, 1'b0);
    run_single("d65535_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0);

    // Divide by zero followed back-to-back by a normal op.
    dividend = 16'd1234;
    divisor  = 8'd0;
    en       = 1'b1;
    step();
    dividend = 16'd100;
    divisor  = 8'd10;
    step();
    en = 1'b0;
    repeat (13) step();
    check("dz_early_rdy", result_rdy, 1'b0);
    step();
    check("dz_rdy", result_rdy, 1'b1);
    check("dz_q", quotient, 16'hFFFF);
    check("dz_r", remainder, 8'd0);
    check("dz_z", div_zero, 1'b1);
    step();
    check("dz_next_rdy", result_rdy, 1'b1);
    check("dz_next_q", quotient, 16'd10);
    check("dz_next_r", remainder, 8'd0);
    check("dz_next_z", div_zero, 1'b0);
    step();
    check("dz_after_rdy", result_rdy, 1'b0);
    last_q = 16'd10;
    last_r = 8'd0;
    last_z = 1'b0;

    // Back-to-back random stream against a / and % reference.
    for (int j = 0; j < 50; j++) begin
      if (j < 32) begin
        a_u      = $urandom_range(0, 65535);
        b_u      = $urandom_range(1, 255);
        dividend = a_u[15:0];
        divisor  = b_u[7:0];
        en       = 1'b1;
        exp_q_fifo.push_back(16'(a_u / b_u));
        exp_r_fifo.push_back(8'(a_u % b_u));
      end else begin
        en = 1'b0;
      end
      step();
      exp_rdy = (j >= 15) && (j < 47);
      check("stream_rdy", result_rdy, exp_rdy);
      if (exp_rdy && exp_q_fifo.size() > 0) begin
        last_q = exp_q_fifo.pop_front();
        last_r = exp_r_fifo.pop_front();
        last_z = 1'b0;
        check("stream_q", quotient, last_q);
        check("stream_r", remainder, last_r);
        check("stream_z", div_zero, 1'b0);
      end
    end
    check("stream_drained", exp_q_fifo.size(), 0);

    // Bubble pattern 1,0,0,1,1,0: valid pattern shifts through, outputs hold.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b0;
    for (int j = 0; j < 24; j++) begin
      en = 1'b0;
      if (j == 0) begin dividend = 16'd500;   divisor = 8'd7;   en = 1'b1; exp_q_fifo.push_back(16'd71);  exp_r_fifo.push_back(8'd3); end
      if (j == 3) begin dividend = 16'd900;   divisor = 8'd13;  en = 1'b1; exp_q_fifo.push_back(16'd69);  exp_r_fifo.push_back(8'd3); end
      if (j == 4) begin dividend = 16'd60000; divisor = 8'd250; en = 1'b1; exp_q_fifo.push_back(16'd240); exp_r_fifo.push_back(8'd0); end
      step();
      exp_rdy = (j >= 15 && j < 21) ? pat[j-15] : 1'b0;
      check("bubble_rdy", result_rdy, exp_rdy);
      if (exp_rdy && exp_q_fifo.size() > 0) begin
        last_q = exp_q_fifo.pop_front();
        last_r = exp_r_fifo.pop_front();
        last_z = 1'b0;
      end
      check("bubble_q", quotient, last_q);
      check("bubble_r", remainder, last_r);
      check("bubble_z", div_zero, last_z);
    end

    // Four ops in flight, then a one-cycle reset at cycle 6 kills them.
    for (int j = 0; j < 6; j++) begin
      en       = (j < 4);
      dividend = 16'(1000 + j);
      divisor  = 8'd3;
      step();
    end
    rst_n    = 1'b0;
    en       = 1'b1;
    dividend = 16'd4321;
    divisor  = 8'd5;
    step();
    rst_n = 1'b1;
    en    = 1'b0;
    check("rst_mid_rdy", result_rdy, 1'b0);
    check("rst_mid_q", quotient, 16'd0);
    check("rst_mid_r", remainder, 8'd0);
    check("rst_mid_z", div_zero, 1'b0);
    run_single("d200_3", 16'd200, 8'd3, 16'd66, 8'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
